// File: rtl/sum_accum_if.sv
// sum_accum_if: handshake bundle for sum_accum_pipe.
//   Input side  : in_valid, in_ready, a, b, op (operand beat, valid/ready)
//   Output side : out_valid, out_ready, result, ovf, count (result beat, valid/ready)
// Modports:
//   master : the producer/consumer surrounding the block (drives operands, out_ready)
//   slave  : the accumulator block itself
interface sum_accum_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             ovf;
  logic [7:0]       count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, ovf, count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, ovf, count
  );
endinterface

// File: rtl/sum_accum_pipe.sv
// sum_accum_pipe: two-stage pipelined pair-adder feeding a wide accumulator.
//   S1 registers psum = a + b (WIDTH+1 bits) and the opcode on an input accept.
//   S2 applies LOAD / ACC / SUB / CLR to the accumulator and presents the new
//   value with an overflow flag over an output valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sum_accum_if.slave (operand handshake in, result handshake out)
// Build option:
//   SUM_ACC_SATURATE_EN defined   -> ACC clamps to all-ones on carry, SUB clamps
//                                    to zero on borrow.
//   SUM_ACC_SATURATE_EN undefined -> modulo 2^ACC_W wrap.
//   In both builds ovf reports the carry/borrow of the op.
module sum_accum_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12
) (
  input  logic      clk,
  input  logic      rst_n,
  sum_accum_if.slave bus
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ACC  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH:0]   s1_psum;
  op_e              s1_op;

  // Stage 2 state; the accumulator register is also the visible result
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic             out_valid_q;
  logic [7:0]       count_q;

  logic             adv;
  logic             accept;
  logic             xfer;
  logic [ACC_W-1:0] psum_wide;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   diff_ext;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  // S2 may take S1's beat whenever its output slot is empty or being drained.
  assign adv          = s1_valid && (!out_valid_q || bus.out_ready);
  // S1 can reload in the same cycle it hands its beat to S2.
  assign bus.in_ready = !s1_valid || adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid_q && bus.out_ready;

  // ---------------------------------------------------------------- stage 1
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_psum  <= '0;
      s1_op    <= OP_LOAD;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_psum  <= {1'b0, bus.a} + {1'b0, bus.b};
      s1_op    <= op_e'(bus.op);
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // One extra bit on both operands exposes carry (add) and borrow (subtract).
  assign psum_wide = ACC_W'(s1_psum);
  assign sum_ext   = {1'b0, acc} + {1'b0, psum_wide};
  assign diff_ext  = {1'b0, acc} - {1'b0, psum_wide};

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    acc_next = acc;
    ovf_next = 1'b0;
    case (s1_op)
      OP_LOAD: acc_next = psum_wide;
      OP_ACC: begin
        ovf_next = sum_ext[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
        acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_next = sum_ext[ACC_W-1:0];
`endif
      end
      OP_SUB: begin
        ovf_next = diff_ext[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
        acc_next = diff_ext[ACC_W] ? '0 : diff_ext[ACC_W-1:0];
`else
        acc_next = diff_ext[ACC_W-1:0];
`endif
      end
      OP_CLR:  acc_next = '0;
      default: acc_next = acc;
    endcase
  end

  // A new advance overrides a same-cycle transfer so out_valid stays high and
  // the fresh result replaces the delivered one on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      acc         <= acc_next;
      ovf_q       <= ovf_next;
      out_valid_q <= 1'b1;
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // Delivered-result counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = acc;
  assign bus.ovf       = ovf_q;
  assign bus.count     = count_q;

endmodule

// File: doc/sum_accum_pipe.md
# sum_accum_pipe

Parametrised, pipelined successor to the top-level combinational byte adder. It accepts operand pairs over a valid/ready handshake and computes a registered pair-sum. That sum loads, adds to, or subtracts from a wide accumulator, or clears it. Each result is returned over a second valid/ready handshake with an overflow flag and a delivered-result counter. It sits behind the tt_um top-level pin mapping, between the `ui_in`/`uio_in` operand pins and `uo_out`.

## Interface
- `WIDTH`, 8: operand width, ≥ 2
- `ACC_W`, 12: accumulator/result width; must satisfy WIDTH+1 ≤ ACC_W ≤ 32
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low; the only reset
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: block can accept a beat
- `a`, `b` in WIDTH: unsigned operands
- `op` in 2: 00 LOAD, 01 ACC, 10 SUB, 11 CLR
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `result` out ACC_W: accumulator value after this op
- `ovf` out 1: this op overflowed/underflowed
- `count` out 8: results delivered; wraps 255→0

## Operation
- **Stage 1 (S1)**, on accept (`in_valid && in_ready`): register `psum = a + b` (WIDTH+1 bits, never truncated) and `op`; set `s1_valid`.
- **Stage 2 (S2)**, on advance, where `adv = s1_valid && (!out_valid || out_ready)`:
  - LOAD: acc = zext(psum), ovf = 0
  - ACC: acc = acc + psum; ovf = carry out of ACC_W
  - SUB: acc = acc − psum; ovf = borrow
  - CLR: acc = 0, ovf = 0; psum ignored
- On each advance: `result` = new acc; `out_valid` = 1.
- The accumulator is updated only in S2, so back-to-back ACC/SUB beats chain with no hazard and no bubble.
- Arithmetic is unsigned, modulo 2^ACC_W unless saturation is compiled in (see Configuration).
- `in_ready` = `!s1_valid || adv` (combinational).
- Output handshake: once `out_valid` = 1, `result` and `ovf` hold stable until `out_ready` = 1.
  - `out_valid` drops on a transfer only if no new advance occurs in that same cycle.
- `count` increments on every output transfer (`out_valid && out_ready`).
- Simultaneous output transfer and advance: the new result replaces the old one in the same edge; `out_valid` stays 1; `count` increments once.
- Simultaneous accept and advance: S1 reloads; no beat is lost.
- `in_valid` low leaves S1 unchanged except as emptied by an advance.

## Timing
- Latency: beat accepted at edge N → `result`/`out_valid` valid after edge N+1.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Stall (`out_ready` = 0 with `out_valid` = 1):
  - S1 may still fill once.
  - `in_ready` then drops in the same cycle S1 becomes occupied.
  - At most 2 beats are in flight.
- Reset values while `rst_n` = 0 (asynchronous, immediate): acc = 0, `result` = 0, `ovf` = 0, `out_valid` = 0, `s1_valid` = 0, `count` = 0, so `in_ready` = 1.
- Reset mid-operation: all in-flight beats are discarded, with no output transfer.
- First accept is possible on the first rising edge after deassertion.

## Configuration
- Macro `SUM_ACC_SATURATE_EN`.
- **Defined:** ACC on carry clamps to 2^ACC_W−1; SUB on borrow clamps to 0. `ovf` = 1 in both cases.
- **Undefined:** modulo wrap; `ovf` still reports carry/borrow.
- LOAD and CLR are identical in both builds.

## Test plan
All scenarios use WIDTH=8, ACC_W=10.
- **LOAD, result check:** LOAD a=200, b=100, `out_ready` = 1 → `result` = 300, `ovf` = 0, `out_valid` one cycle after accept, `count` = 1.
- **ACC overflow:** CLR, then 3× ACC a=255, b=255 back-to-back → results 510, 1020, then 506 with `ovf` = 1. With the macro defined, the third result is 1023 with `ovf` = 1.
- **SUB underflow:** LOAD 2+3 (=5), then SUB a=3, b=4 → 1022 with `ovf` = 1. With the macro defined, 0 with `ovf` = 1.
- **Backpressure:** hold `out_ready` = 0 and offer 3 ACC beats of 1+0 from 0:
  - first result (1) holds stable;
  - second beat sits in S1;
  - `in_ready` = 0 before the third beat.
  - Release `out_ready` → results 1, 2, 3 in order, no loss, `count` = 3.
- **Throughput:** 20 consecutive ACC beats of 1+1 with `out_ready` = 1 → 20 consecutive cycles of `out_valid`, results 2..40, `count` = 20.
- **Reset mid-operation:** assert `rst_n` = 0 with both stages full → all outputs 0 and `in_ready` = 1 immediately. After release, LOAD 7+8 → 15.
